// File: rtl/tdm_demux_1x4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x4
//   Receive end of a 4-slot TDM link. The transmitter sends channels a,b,c,d
//   as slots 0..3, one slot per slot_en strobe, and marks slot 0 with
//   frame_sync. A HUNT/VERIFY/LOCKED state machine acquires and tracks frame
//   alignment. Once locked, each complete frame is presented on a..d, with all
//   four channels updating together.
//
// Ports
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   slot_en      in   1       din carries one valid slot this cycle
//   din          in   DATA_W  slot data, sampled only when slot_en=1
//   frame_sync   in   1       marks slot 0, meaningful only when slot_en=1
//   a,b,c,d      out  DATA_W  channel outputs for slots 0..3 (registered)
//   frame_valid  out  1       one-cycle pulse: a..d just took a new frame
//   locked       out  1       high while in LOCKED
//   sync_err     out  1       one-cycle pulse: frame_sync missing or misplaced
// ---------------------------------------------------------------------------
module tdm_demux_1x4 #(
    parameter int DATA_W      = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slot_en,
    input  logic [DATA_W-1:0] din,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TH = LOCK_FRAMES[3:0];
    localparam logic [3:0] LOSS_TH = LOSS_FRAMES[3:0];

    state_t            state_r;
    logic [1:0]        slot_cnt_r;
    logic [3:0]        good_cnt_r;
    logic [3:0]        bad_cnt_r;
    // Set once the current locked frame has already been counted as bad, so
    // further offences in the same frame do not count again.
    logic              bad_frame_r;
    // Slot 3 goes straight to d, so only slots 0..2 need holding.
    logic [DATA_W-1:0] shadow0_r;
    logic [DATA_W-1:0] shadow1_r;
    logic [DATA_W-1:0] shadow2_r;

    logic              slot0_s;
    logic              offence_s;
    logic              first_offence_s;
    logic              lose_lock_s;
    logic [3:0]        good_cnt_inc_s;
    logic [3:0]        bad_cnt_inc_s;

    // Decode of the current slot against the alignment counter.
    always_comb begin
        slot0_s         = (slot_cnt_r == 2'd0);
        // Offence: sync missing on the expected slot 0, or present elsewhere.
        offence_s       = slot0_s ? ~frame_sync : frame_sync;
        first_offence_s = offence_s & ~bad_frame_r;
        good_cnt_inc_s  = good_cnt_r + 4'd1;
        bad_cnt_inc_s   = bad_cnt_r + 4'd1;
        lose_lock_s     = first_offence_s & (bad_cnt_inc_s >= LOSS_TH);
    end

    // Alignment FSM, shadow capture and registered channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HUNT;
            slot_cnt_r  <= 2'd0;
            good_cnt_r  <= 4'd0;
            bad_cnt_r   <= 4'd0;
            bad_frame_r <= 1'b0;
            shadow0_r   <= {DATA_W{1'b0}};
            shadow1_r   <= {DATA_W{1'b0}};
            shadow2_r   <= {DATA_W{1'b0}};
            a           <= {DATA_W{1'b0}};
            b           <= {DATA_W{1'b0}};
            c           <= {DATA_W{1'b0}};
            d           <= {DATA_W{1'b0}};
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (slot_en) begin
                case (state_r)
                    ST_HUNT: begin
                        if (frame_sync) begin
                            shadow0_r  <= din;
                            slot_cnt_r <= 2'd1;
                            good_cnt_r <= 4'd1;
                            state_r    <= ST_VERIFY;
                        end else begin
                            state_r    <= ST_HUNT;
                        end
                    end
                    ST_VERIFY: begin
                        if (slot0_s) begin
                            if (frame_sync) begin
                                shadow0_r  <= din;
                                slot_cnt_r <= 2'd1;
                                good_cnt_r <= good_cnt_inc_s;
                                if (good_cnt_inc_s >= LOCK_TH) begin
                                    state_r     <= ST_LOCKED;
                                    locked      <= 1'b1;
                                    bad_cnt_r   <= 4'd0;
                                    bad_frame_r <= 1'b0;
                                end else begin
                                    state_r     <= ST_VERIFY;
                                end
                            end else begin
                                sync_err   <= 1'b1;
                                state_r    <= ST_HUNT;
                                slot_cnt_r <= 2'd0;
                                good_cnt_r <= 4'd0;
                            end
                        end else if (frame_sync) begin
                            // Early sync: realign on it and restart the count.
                            sync_err   <= 1'b1;
                            shadow0_r  <= din;
                            slot_cnt_r <= 2'd1;
                            good_cnt_r <= 4'd1;
                        end else begin
                            slot_cnt_r <= slot_cnt_r + 2'd1;
                            case (slot_cnt_r)
                                2'd1:    shadow1_r <= din;
                                2'd2:    shadow2_r <= din;
                                default: shadow2_r <= shadow2_r;
                            endcase
                        end
                    end
                    ST_LOCKED: begin
                        sync_err <= offence_s;
                        if (lose_lock_s) begin
                            // Frame in flight is dropped; a..d keep the last frame.
                            state_r     <= ST_HUNT;
                            locked      <= 1'b0;
                            slot_cnt_r  <= 2'd0;
                            good_cnt_r  <= 4'd0;
                            bad_cnt_r   <= 4'd0;
                            bad_frame_r <= 1'b0;
                        end else begin
                            slot_cnt_r <= slot_cnt_r + 2'd1;
                            case (slot_cnt_r)
                                2'd0: begin
                                    shadow0_r   <= din;
                                    bad_frame_r <= bad_frame_r | offence_s;
                                    if (first_offence_s) begin
                                        bad_cnt_r <= bad_cnt_inc_s;
                                    end else begin
                                        bad_cnt_r <= bad_cnt_r;
                                    end
                                end
                                2'd1: begin
                                    shadow1_r   <= din;
                                    bad_frame_r <= bad_frame_r | offence_s;
                                    if (first_offence_s) begin
                                        bad_cnt_r <= bad_cnt_inc_s;
                                    end else begin
                                        bad_cnt_r <= bad_cnt_r;
                                    end
                                end
                                2'd2: begin
                                    shadow2_r   <= din;
                                    bad_frame_r <= bad_frame_r | offence_s;
                                    if (first_offence_s) begin
                                        bad_cnt_r <= bad_cnt_inc_s;
                                    end else begin
                                        bad_cnt_r <= bad_cnt_r;
                                    end
                                end
                                default: begin
                                    // Last slot: publish the whole frame at once.
                                    a           <= shadow0_r;
                                    b           <= shadow1_r;
                                    c           <= shadow2_r;
                                    d           <= din;
                                    frame_valid <= 1'b1;
                                    bad_frame_r <= 1'b0;
                                    if (!(bad_frame_r | offence_s)) begin
                                        bad_cnt_r <= 4'd0;
                                    end else if (first_offence_s) begin
                                        bad_cnt_r <= bad_cnt_inc_s;
                                    end else begin
                                        bad_cnt_r <= bad_cnt_r;
                                    end
                                end
                            endcase
                        end
                    end
                    default: begin
                        state_r    <= ST_HUNT;
                        locked     <= 1'b0;
                        slot_cnt_r <= 2'd0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x4
//   Scoreboard bench for tdm_demux_1x4. Stimulus is applied on the falling
//   edge. For every cycle a reference model pushes the expected flags and
//   outputs into a queue, and every frame it expects to be published goes
//   into a frame queue. A monitor samples 1 time unit after each rising edge
//   and pops from these queues.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x4;

    localparam int DW    = 8;
    localparam int LOCKF = 2;
    localparam int LOSSF = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          slot_en = 1'b0;
    logic          frame_sync = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] a, b, c, d;
    logic          frame_valid, locked, sync_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdm_demux_1x4 #(.DATA_W(DW), .LOCK_FRAMES(LOCKF), .LOSS_FRAMES(LOSSF)) dut (
        .clk(clk), .rst_n(rst_n), .slot_en(slot_en), .din(din),
        .frame_sync(frame_sync), .a(a), .b(b), .c(c), .d(d),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    typedef struct packed {
        logic        lk;
        logic        se;
        logic        fv;
        logic [31:0] dat;
    } exp_t;

    exp_t        cyc_q[$];
    logic [31:0] frm_q[$];

    // Reference model: mode 0=hunting, 1=verifying, 2=locked.
    int       m_mode;
    int       m_pos;
    int       m_good;
    int       m_bad;
    bit       m_frame_bad;
    bit [7:0] m_frame[4];
    bit [7:0] m_out[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_frame_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_frame[i] = 8'd0;
            m_out[i]   = 8'd0;
        end
    endtask

    task automatic model_step(input bit en, input bit fs, input bit [7:0] dv, output exp_t e);
        bit off;
        e = '0;
        if (en) begin
            if (m_mode == 0) begin
                if (fs) begin
                    m_mode = 1; m_pos = 1; m_good = 1; m_frame[0] = dv;
                end
            end else if (m_mode == 1) begin
                if (m_pos == 0 && fs) begin
                    m_good++; m_frame[0] = dv; m_pos = 1;
                    if (m_good >= LOCKF) begin
                        m_mode = 2; m_bad = 0; m_frame_bad = 1'b0;
                    end
                end else if (m_pos == 0) begin
                    e.se = 1'b1; m_mode = 0;
                end else if (fs) begin
                    e.se = 1'b1; m_frame[0] = dv; m_pos = 1; m_good = 1;
                end else begin
                    m_frame[m_pos] = dv; m_pos = (m_pos + 1) % 4;
                end
            end else begin
                off = (m_pos == 0) ? !fs : fs;
                if (off) e.se = 1'b1;
                if (off && !m_frame_bad) begin
                    m_bad++; m_frame_bad = 1'b1;
                    if (m_bad >= LOSSF) m_mode = 0;
                end
                if (m_mode == 2) begin
                    m_frame[m_pos] = dv;
                    if (m_pos == 3) begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                        e.fv = 1'b1;
                        frm_q.push_back({m_out[0], m_out[1], m_out[2], m_out[3]});
                        if (!m_frame_bad) m_bad = 0;
                        m_frame_bad = 1'b0;
                    end
                    m_pos = (m_pos + 1) % 4;
                end
            end
        end
        e.lk  = (m_mode == 2);
        e.dat = {m_out[0], m_out[1], m_out[2], m_out[3]};
    endtask

    task automatic drive(input bit en, input bit fs, input bit [7:0] dv);
        exp_t e;
        @(negedge clk);
        slot_en = en; frame_sync = fs; din = dv;
        model_step(en, fs, dv, e);
        cyc_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0; slot_en = 1'b0; frame_sync = 1'b0;
        model_reset();
        #1;
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_outputs", {a, b, c, d}, 32'd0);
        check("reset_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
        e = '0;
        cyc_q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(1'b0, 1'b0, 8'd0, e);
        cyc_q.push_back(e);
    endtask

    // fsm bit i = frame_sync on slot i; gap_max idle cycles (random sync) before each slot.
    task automatic send_frame(input bit [31:0] data, input bit [3:0] fsm, input int gap_max, input int nslots);
        bit [7:0] dv;
        for (int i = 0; i < nslots; i++) begin
            for (int g = 0; g < $urandom_range(gap_max, 0); g++)
                drive(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
            dv = data[31 - 8*i -: 8];
            drive(1'b1, fsm[i], dv);
        end
    endtask

    // Post-edge sample for directed checks.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one scoreboard entry per clock, one frame entry per frame_valid.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("locked", 32'(locked), 32'(e.lk));
                check("sync_err", 32'(sync_err), 32'(e.se));
                check("frame_valid", 32'(frame_valid), 32'(e.fv));
                check("outputs_abcd", {a, b, c, d}, e.dat);
                if (frame_valid === 1'b1) begin
                    checks++;
                    if (frm_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected actual=%h required=none", {a, b, c, d});
                    end else if ({a, b, c, d} !== frm_q[0]) begin
                        failures++;
                        $display("FAIL frame_data actual=%h required=%h", {a, b, c, d}, frm_q.pop_front());
                    end else begin
                        void'(frm_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        int wait_cnt;
        model_reset();
        // 1: two aligned frames lock; only the second is output.
        do_reset();
        send_frame(32'hA1B2C3D4, 4'b0001, 0, 4);
        send_frame(32'h11223344, 4'b0001, 0, 4);
        settle();
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_data", {a, b, c, d}, 32'h11223344);
        // 2: gaps between slots, sync toggling on idle cycles.
        send_frame(32'h55667788, 4'b0001, 3, 4);
        settle();
        check("t2_data", {a, b, c, d}, 32'h55667788);
        // 3: one unsynced frame keeps lock, then two lose it.
        send_frame(32'h01020304, 4'b0000, 1, 4);
        settle();
        check("t3_locked_held", 32'(locked), 32'd1);
        check("t3_data", {a, b, c, d}, 32'h01020304);
        send_frame(32'h05060708, 4'b0001, 0, 4);
        send_frame(32'h090A0B0C, 4'b0000, 0, 4);
        send_frame(32'h0D0E0F10, 4'b0000, 0, 4);
        settle();
        check("t3_lock_lost", 32'(locked), 32'd0);
        check("t3_hold", {a, b, c, d}, 32'h090A0B0C);
        // 4: sync on slot 2 during VERIFY realigns.
        drive(1'b1, 1'b1, 8'h21);
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b1, 8'h31);
        settle();
        check("t4_sync_err", 32'(sync_err), 32'd1);
        send_frame(32'h00323334, 4'b0000, 1, 3);
        settle();
        check("t4_not_yet", 32'(locked), 32'd0);
        send_frame(32'h41424344, 4'b0001, 1, 4);
        settle();
        check("t4_locked", 32'(locked), 32'd1);
        check("t4_data", {a, b, c, d}, 32'h41424344);
        // 5: reset mid locked frame, then unsynced slots stay in HUNT.
        send_frame(32'h61620000, 4'b0001, 0, 2);
        do_reset();
        send_frame(32'h71727374, 4'b0000, 1, 4);
        send_frame(32'h75767778, 4'b0000, 1, 4);
        settle();
        check("t5_locked", 32'(locked), 32'd0);
        check("t5_outputs", {a, b, c, d}, 32'd0);
        // Randomised frames with occasional faults and slips.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(19, 0);
            case (r)
                0:       send_frame($urandom, 4'b0000, 2, 4);
                1:       send_frame($urandom, 4'(4'b0001 | (4'b0001 << $urandom_range(3, 1))), 2, 4);
                2:       send_frame($urandom, 4'(4'b0001 << $urandom_range(3, 1)), 2, 4);
                3:       send_frame($urandom, 4'b0001, 2, $urandom_range(3, 1));
                default: send_frame($urandom, 4'b0001, 2, 4);
            endcase
        end
        drive(1'b0, 1'b0, 8'd0);
        wait_cnt = 0;
        while (cyc_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        check("drain_cycle_q", cyc_q.size(), 32'd0);
        check("drain_frame_q", frm_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
